// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads a combinational ROM and buffers {instr, pc} in 2 entries.
// One-cycle fetch latency; a redirect flushes the buffer and retargets the PC in the same cycle.
module instr_fetch #(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  input  logic              out_ready,
  output logic [31:0]       fetch_pc
);

  logic [31:0] pc;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] instr_mem [2];
  logic [31:0] pc_mem    [2];

  logic pop;
  logic push;
  logic unused_bits;

  // Byte-offset bits of the redirect target are discarded.
  assign unused_bits = ^redirect_pc[1:0];

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = ~redirect_valid & ((count != 2'd2) | pop);

  assign rom_addr  = pc[ADDR_W+1:2];
  assign fetch_pc  = pc;
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Buffer payload carries no reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= rom_instr;
      pc_mem[wr_ptr]    <= pc;
    end
  end

endmodule
